// File: rtl/sw_key_stimulus_driver_pkg.sv
// Shared definitions for the automated switch/KEY[0] operand-entry driver:
// state encoding, debouncer threshold and operand index constants.
package sw_key_stimulus_driver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        PRESS,
        GAP,
        WAIT_DONE,
        END
    } stim_state_t;

    // Debouncer on the entry side needs this many stable cycles before it accepts a level.
    localparam int DEBOUNCE_THRESH = 1000;

    localparam int NUM_OPS = 4;

    localparam logic [1:0] OP_A = 2'd0;
    localparam logic [1:0] OP_B = 2'd1;
    localparam logic [1:0] OP_C = 2'd2;
    localparam logic [1:0] OP_D = 2'd3;

    // True when a cycle count is non-zero and its terminal value fits in a width-bit counter.
    function automatic bit cyc_fits(input longint val, input int width);
        return (val >= 1) && (val <= ((longint'(1) << width) - 1));
    endfunction

endpackage

// File: rtl/stim_cycle_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count compare,
// shared by every timed phase of the stimulus driver.
module stim_cycle_timer #(
    parameter int CNT_W = 20
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign tc = (cnt_reg == tc_val);

endmodule

// File: rtl/sw_key_stimulus_driver.sv
// Emulates an operator entering operands a..d on SW[16:0] and KEY[0], then
// waits (with timeout) for the execution side to report done.
module sw_key_stimulus_driver
    import sw_key_stimulus_driver_pkg::*;
#(
    parameter int SETTLE_CYC  = 2048,
    parameter int PRESS_CYC   = 16,
    parameter int GAP_CYC     = 64,
    parameter int TIMEOUT_CYC = 1048575,
    parameter int CNT_W       = 20
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic        go,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic [15:0] op_c,
    input  logic [15:0] op_d,
    input  logic        done_in,
    output logic [16:0] sw_out,
    output logic        key0_n,
    output logic [1:0]  op_idx,
    output logic        busy,
    output logic        finished,
    output logic        timed_out
);

    if ((SETTLE_CYC <= DEBOUNCE_THRESH) || !cyc_fits(SETTLE_CYC, CNT_W) ||
        !cyc_fits(PRESS_CYC, CNT_W) || !cyc_fits(GAP_CYC, CNT_W) ||
        !cyc_fits(TIMEOUT_CYC, CNT_W)) begin : g_bad_params
        $error("sw_key_stimulus_driver: cycle parameters out of range");
    end

    stim_state_t      state_reg;
    logic [16:0]      sw_out_reg;
    logic             key0_n_reg;
    logic [1:0]       op_idx_reg;
    logic             busy_reg;
    logic             finished_reg;
    logic             timed_out_reg;

    logic             capture;
    logic             timer_clr;
    logic             tc;
    logic [CNT_W-1:0] tc_val;
    logic [15:0]      op_vec   [NUM_OPS];
    logic [15:0]      shadow_q [NUM_OPS];

    assign capture   = (state_reg == IDLE) && go;
    assign op_vec[0] = op_a;
    assign op_vec[1] = op_b;
    assign op_vec[2] = op_c;
    assign op_vec[3] = op_d;

    // Operand snapshot: later changes on op_* must not reach sw_out mid-sequence.
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_shadow
        logic [15:0] slot_reg;
        always_ff @(posedge CLOCK_50 or negedge rst) begin
            if (!rst) begin
                slot_reg <= '0;
            end else if (capture) begin
                slot_reg <= op_vec[gi];
            end
        end
        assign shadow_q[gi] = slot_reg;
    end

    always_comb begin
        tc_val    = '0;
        timer_clr = 1'b0;
        unique case (state_reg)
            IDLE:      timer_clr = 1'b1;
            LOAD:      timer_clr = 1'b1;
            SETTLE: begin
                tc_val    = CNT_W'(SETTLE_CYC - 1);
                timer_clr = tc;
            end
            PRESS: begin
                tc_val    = CNT_W'(PRESS_CYC - 1);
                timer_clr = tc;
            end
            GAP: begin
                tc_val    = CNT_W'(GAP_CYC - 1);
                timer_clr = tc;
            end
            WAIT_DONE: begin
                tc_val    = CNT_W'(TIMEOUT_CYC - 1);
                timer_clr = tc || done_in;
            end
            END:       timer_clr = 1'b1;
            default:   timer_clr = 1'b1;
        endcase
    end

    stim_cycle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .CLOCK_50(CLOCK_50),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (1'b1),
        .load    (1'b0),
        .load_val('0),
        .tc_val  (tc_val),
        .tc      (tc)
    );

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            sw_out_reg    <= '0;
            key0_n_reg    <= 1'b1;
            op_idx_reg    <= OP_A;
            busy_reg      <= 1'b0;
            finished_reg  <= 1'b0;
            timed_out_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (go) begin
                        busy_reg      <= 1'b1;
                        op_idx_reg    <= OP_A;
                        finished_reg  <= 1'b0;
                        timed_out_reg <= 1'b0;
                        state_reg     <= LOAD;
                    end
                end
                LOAD: begin
                    sw_out_reg <= {1'b1, shadow_q[op_idx_reg]};
                    state_reg  <= SETTLE;
                end
                SETTLE: begin
                    if (tc) begin
                        key0_n_reg <= 1'b0;
                        state_reg  <= PRESS;
                    end
                end
                PRESS: begin
                    if (tc) begin
                        key0_n_reg <= 1'b1;
                        state_reg  <= GAP;
                    end
                end
                GAP: begin
                    if (tc) begin
                        if (op_idx_reg == OP_D) begin
                            state_reg <= WAIT_DONE;
                        end else begin
                            op_idx_reg <= op_idx_reg + 2'd1;
                            state_reg  <= LOAD;
                        end
                    end
                end
                WAIT_DONE: begin
                    // done_in takes priority when it coincides with the timeout.
                    if (done_in) begin
                        finished_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        sw_out_reg   <= '0;
                        state_reg    <= END;
                    end else if (tc) begin
                        timed_out_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        sw_out_reg    <= '0;
                        state_reg     <= END;
                    end
                end
                END: begin
                    sw_out_reg <= '0;
                    key0_n_reg <= 1'b1;
                    if (!go) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sw_out    = sw_out_reg;
    assign key0_n    = key0_n_reg;
    assign op_idx    = op_idx_reg;
    assign busy      = busy_reg;
    assign finished  = finished_reg;
    assign timed_out = timed_out_reg;

endmodule

// File: tb/tb_sw_key_stimulus_driver.sv
// Scoreboard bench: stimulus pushes expected presses/completions, a monitor
// pops and checks them on each key0_n release and each busy fall.
module tb_sw_key_stimulus_driver;

    localparam int FIRST_FALL = 2049;
    localparam int SPACING    = 2129;
    localparam int PRESS_LEN  = 16;
    localparam int TMO_DELTA  = 64 + 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic [15:0] op_a = '0, op_b = '0, op_c = '0, op_d = '0;
    logic        done_in = 1'b0;
    logic [16:0] sw_out;
    logic        key0_n;
    logic [1:0]  op_idx;
    logic        busy, finished, timed_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          is_done;
        logic [15:0] val;
        logic [1:0]  idx;
        int          delta;
        bit          fin;
        bit          tmo;
    } exp_t;

    exp_t exp_q[$];

    sw_key_stimulus_driver #(
        .TIMEOUT_CYC(100)
    ) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .go       (go),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_c     (op_c),
        .op_d     (op_d),
        .done_in  (done_in),
        .sw_out   (sw_out),
        .key0_n   (key0_n),
        .op_idx   (op_idx),
        .busy     (busy),
        .finished (finished),
        .timed_out(timed_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic push_press(input logic [15:0] v, input logic [1:0] i, input int d);
        exp_t e;
        e.is_done = 1'b0; e.val = v; e.idx = i; e.delta = d; e.fin = 1'b0; e.tmo = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input logic [15:0] a, b, c, d);
        push_press(a, 2'd0, FIRST_FALL);
        push_press(b, 2'd1, SPACING);
        push_press(c, 2'd2, SPACING);
        push_press(d, 2'd3, SPACING);
    endtask

    task automatic push_done(input bit f, input bit t, input int d);
        exp_t e;
        e.is_done = 1'b1; e.val = '0; e.idx = '0; e.delta = d; e.fin = f; e.tmo = t;
        exp_q.push_back(e);
    endtask

    // Returns just after the clock edge on which the n-th key0_n transition occurred.
    task automatic wait_key(input bit rising, input int n, input int maxcyc, input string name);
        logic prev = key0_n;
        int   seen = 0;
        for (int i = 0; i < maxcyc; i++) begin
            @(posedge clk); #1;
            if (rising ? (!prev && key0_n) : (prev && !key0_n)) seen++;
            prev = key0_n;
            if (seen == n) return;
        end
        checks++; errors++;
        $display("FAIL %s timeout actual=%0d edges required=%0d", name, seen, n);
    endtask

    task automatic wait_idle(input int maxcyc, input string name);
        for (int i = 0; i < maxcyc; i++) begin
            @(posedge clk); #1;
            if (!busy) return;
        end
        checks++; errors++;
        $display("FAIL %s timeout actual busy=1 required busy=0", name);
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    // done_in high exactly on the edge that is 'after' cycles past the last release.
    task automatic done_at(input int after);
        repeat (after - 1) @(posedge clk);
        #1 done_in = 1'b1;
        @(posedge clk); #1 done_in = 1'b0;
    endtask

    // Monitor
    initial begin
        logic prev_key = 1'b1;
        logic prev_busy = 1'b0;
        int   last_fall = 0, last_rise = 0, fall_delta = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_key = 1'b1;
                prev_busy = 1'b0;
            end else begin
                if (busy && !prev_busy) last_fall = cyc;
                if (prev_key && !key0_n) begin
                    fall_delta = cyc - last_fall;
                    last_fall = cyc;
                end
                if (!prev_key && key0_n) begin
                    last_rise = cyc;
                    $display("PRESS idx=%0d sw=%05h len=%0d dt=%0d", op_idx, sw_out, cyc - last_fall, fall_delta);
                    if (exp_q.size() == 0 || exp_q[0].is_done) begin
                        checks++; errors++;
                        $display("FAIL unexpected_press actual=idx%0d required=none", op_idx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("press_value", sw_out[15:0], e.val);
                        chk("press_enter", sw_out[16], 1);
                        chk("press_idx", op_idx, e.idx);
                        chk("press_len", cyc - last_fall, PRESS_LEN);
                        chk("press_spacing", fall_delta, e.delta);
                    end
                end
                if (prev_busy && !busy) begin
                    $display("DONE fin=%0d tmo=%0d sw=%05h dt=%0d", finished, timed_out, sw_out, cyc - last_rise);
                    if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done actual=busy_fall required=press_or_none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_finished", finished, e.fin);
                        chk("done_timed_out", timed_out, e.tmo);
                        chk("done_sw_out", sw_out, 0);
                        chk("done_key0_n", key0_n, 1);
                        chk("done_latency", cyc - last_rise, e.delta);
                    end
                end
                prev_key = key0_n;
                prev_busy = busy;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_sw_out", sw_out, 0);
        chk("rst_key0_n", key0_n, 1);
        chk("rst_op_idx", op_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);
        chk("rst_timed_out", timed_out, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Basic entry, timing, and operand snapshot (op_b changes during SETTLE of a)
        op_a = 16'h1234; op_b = 16'h00FF; op_c = 16'h8000; op_d = 16'hFFFF;
        push_seq(16'h1234, 16'h00FF, 16'h8000, 16'hFFFF);
        push_done(1'b1, 1'b0, 80);
        pulse_go();
        repeat (100) @(posedge clk);
        #1 op_b = 16'hDEAD;
        wait_key(1'b1, 4, 10000, "basic_presses");
        done_at(80);
        wait_idle(200, "basic_idle");
        @(negedge clk);
        chk("basic_finished", finished, 1);
        chk("basic_busy", busy, 0);

        // done_in on the timeout cycle, with go held high throughout
        op_a = 16'h0001; op_b = 16'h0002; op_c = 16'h0003; op_d = 16'h0004;
        push_seq(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        push_done(1'b1, 1'b0, TMO_DELTA);
        @(posedge clk); #1 go = 1'b1;
        wait_key(1'b1, 4, 10000, "simul_presses");
        done_at(TMO_DELTA);
        wait_idle(200, "simul_idle");
        repeat (3000) @(posedge clk);
        #1;
        chk("hold_go_busy", busy, 0);
        chk("hold_go_finished", finished, 1);
        chk("hold_go_timed_out", timed_out, 0);
        go = 1'b0;
        repeat (3) @(posedge clk);

        // Timeout with done_in low
        op_a = 16'hAAAA; op_b = 16'h5555; op_c = 16'h0F0F; op_d = 16'hF0F0;
        push_seq(16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0);
        push_done(1'b0, 1'b1, TMO_DELTA);
        pulse_go();
        wait_key(1'b1, 4, 10000, "tmo_presses");
        wait_idle(300, "tmo_idle");
        @(negedge clk);
        chk("tmo_timed_out", timed_out, 1);
        chk("tmo_finished", finished, 0);
        chk("tmo_sw_out", sw_out, 0);
        repeat (3) @(posedge clk);

        // Reset during the second press, then a full re-run from operand a
        op_a = 16'h1111; op_b = 16'h2222; op_c = 16'h3333; op_d = 16'h4444;
        push_press(16'h1111, 2'd0, FIRST_FALL);
        pulse_go();
        wait_key(1'b0, 2, 6000, "rst_second_press");
        #2 rst = 1'b0;
        #1;
        chk("midrst_key0_n", key0_n, 1);
        chk("midrst_sw_out", sw_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_op_idx", op_idx, 0);
        chk("midrst_timed_out", timed_out, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        push_seq(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        push_done(1'b1, 1'b0, 80);
        pulse_go();
        wait_key(1'b1, 4, 10000, "rerun_presses");
        done_at(80);
        wait_idle(200, "rerun_idle");
        repeat (3) @(posedge clk);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
